// File: rtl/i2s_tx.sv
// I2S serial transmitter: one stereo pair per frame, all pacing from mclk_tick.
module i2s_tx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SLOT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mclk_tick,
    input  logic              lrck_in,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sclk_out,
    output logic              ws_out,
    output logic              sdata_out,
    output logic              busy,
    output logic              underrun
);
    localparam int unsigned FRAME_H = 4 * SLOT_W;
    localparam int unsigned H_W     = $clog2(FRAME_H);
    localparam int unsigned B_W     = H_W - 1;
    localparam int unsigned I_W     = $clog2(DATA_W);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [H_W-1:0]    h_q, h_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] shl_q, shl_d;
    logic [DATA_W-1:0] shr_q, shr_d;
    logic              lrck_d_q, lrck_d_d;
    logic              ready_q, ready_d;
    logic              sclk_q, sclk_d;
    logic              ws_q, ws_d;
    logic              sdata_q, sdata_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;

    logic              edge_c;
    logic              xfer_c;
    logic [B_W-1:0]    bit_idx;
    logic [B_W-1:0]    pos;
    logic [I_W-1:0]    sel;
    logic [DATA_W-1:0] word;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            h_q        <= '0;
            full_q     <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            shl_q      <= '0;
            shr_q      <= '0;
            lrck_d_q   <= 1'b1;
            ready_q    <= 1'b0;
            sclk_q     <= 1'b0;
            ws_q       <= 1'b0;
            sdata_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            full_q     <= full_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            shl_q      <= shl_d;
            shr_q      <= shr_d;
            lrck_d_q   <= lrck_d_d;
            ready_q    <= ready_d;
            sclk_q     <= sclk_d;
            ws_q       <= ws_d;
            sdata_q    <= sdata_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    // Next state: frame sequencing, holding register, and output mapping from next h.
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        shl_d      = shl_q;
        shr_d      = shr_q;
        lrck_d_d   = lrck_in;
        underrun_d = 1'b0;
        sclk_d     = 1'b0;
        ws_d       = 1'b0;
        sdata_d    = 1'b0;

        edge_c = lrck_in & ~lrck_d_q;
        xfer_c = sample_valid & ready_q;

        case (state_q)
            IDLE: begin
                if (edge_c) begin
                    state_d = RUN;
                    h_d     = '0;
                    if (full_q) begin
                        shl_d  = hold_l_q;
                        shr_d  = hold_r_q;
                        full_d = 1'b0;
                    end else begin
                        shl_d      = '0;
                        shr_d      = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Frame always completes; lrck edges are not looked at here.
                if (mclk_tick) begin
                    if (h_q == H_W'(FRAME_H - 1)) begin
                        state_d = IDLE;
                        h_d     = '0;
                    end else begin
                        h_d = h_q + H_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer in the frame-start cycle is held for the following frame.
        if (xfer_c) begin
            hold_l_d = sample_l;
            hold_r_d = sample_r;
            full_d   = 1'b1;
        end

        ready_d = ~full_d;
        busy_d  = (state_d == RUN);

        bit_idx = h_d[H_W-1:1];
        ws_d    = (state_d == RUN) && (bit_idx >= B_W'(SLOT_W));
        pos     = ws_d ? (bit_idx - B_W'(SLOT_W)) : bit_idx;
        word    = ws_d ? shr_d : shl_d;
        sel     = I_W'(B_W'(DATA_W) - pos);
        if (state_d == RUN) begin
            sclk_d = h_d[0];
            // Slot position 0 is the one-bit I2S delay after the ws edge.
            if ((pos >= B_W'(1)) && (pos <= B_W'(DATA_W))) begin
                sdata_d = word[sel];
            end
        end
    end

    assign sample_ready = ready_q;
    assign sclk_out     = sclk_q;
    assign ws_out       = ws_q;
    assign sdata_out    = sdata_q;
    assign busy         = busy_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-level reference model plus per-cycle output comparison.
module tb_i2s_tx;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SLOT_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mclk_tick = 1'b0;
    logic        lrck_in = 1'b1;
    logic [15:0] sample_l = 16'h0;
    logic [15:0] sample_r = 16'h0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        sclk_out;
    logic        ws_out;
    logic        sdata_out;
    logic        busy;
    logic        underrun;

    always #5 clk = ~clk;

    i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mclk_tick    (mclk_tick),
        .lrck_in      (lrck_in),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sclk_out     (sclk_out),
        .ws_out       (ws_out),
        .sdata_out    (sdata_out),
        .busy         (busy),
        .underrun     (underrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit stream of one frame in time order, first bit in the MSB.
    function automatic logic [63:0] stream_of(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
    endfunction

    // Reference model: frame/ticks/holding-register view of the transmitter.
    bit          m_busy = 1'b0;
    bit          m_full = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_underrun = 1'b0;
    bit          m_lrck_prev = 1'b1;
    int          m_ticks = 0;
    logic [63:0] m_stream = 64'd0;
    logic [15:0] m_hl = 16'h0;
    logic [15:0] m_hr = 16'h0;
    bit          mdl_edge;
    bit          mdl_xfer;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 1'b0; m_full = 1'b0; m_ready = 1'b0; m_underrun = 1'b0;
            m_lrck_prev = 1'b1; m_ticks = 0; m_stream = 64'd0;
        end else begin
            mdl_edge    = lrck_in && !m_lrck_prev;
            m_lrck_prev = lrck_in;
            mdl_xfer    = sample_valid && m_ready;
            m_underrun  = 1'b0;
            if (!m_busy) begin
                if (mdl_edge) begin
                    m_busy  = 1'b1;
                    m_ticks = 0;
                    if (m_full) begin
                        m_stream = stream_of(m_hl, m_hr);
                        m_full   = 1'b0;
                    end else begin
                        m_stream   = 64'd0;
                        m_underrun = 1'b1;
                    end
                end
            end else if (mclk_tick) begin
                if (m_ticks == 4 * SLOT_W - 1) m_busy = 1'b0;
                else m_ticks++;
            end
            if (mdl_xfer) begin
                m_hl   = sample_l;
                m_hr   = sample_r;
                m_full = 1'b1;
            end
            m_ready = !m_full;
        end
    end

    // Compare process and frame observation counters.
    logic [63:0] cap = 64'd0;
    int          ncap = 0;
    int          busy_acc = 0;
    int          und_acc = 0;
    logic        sclk_prev = 1'b0;

    task automatic check_cycle();
        int   b;
        logic e_s, e_w, e_d;
        b   = m_ticks / 2;
        e_s = m_busy && ((m_ticks % 2) != 0);
        e_w = m_busy && (b >= SLOT_W);
        e_d = m_busy ? m_stream[63 - b] : 1'b0;
        check("sample_ready", 64'(sample_ready), 64'(m_ready));
        check("busy", 64'(busy), 64'(m_busy));
        check("underrun", 64'(underrun), 64'(m_underrun));
        check("sclk_out", 64'(sclk_out), 64'(e_s));
        check("ws_out", 64'(ws_out), 64'(e_w));
        check("sdata_out", 64'(sdata_out), 64'(e_d));
        if (sclk_out === 1'b1 && sclk_prev !== 1'b1) begin
            cap  = {cap[62:0], sdata_out};
            ncap = ncap + 1;
        end
        sclk_prev = sclk_out;
        if (busy === 1'b1) busy_acc = busy_acc + 1;
        if (underrun === 1'b1) und_acc = und_acc + 1;
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        check_cycle();
    end

    // Stimulus helpers: tick generator, pending-pair queue, frame control.
    int          phase = 0;
    logic [31:0] pend[$];
    int          cap_base = 0;
    int          busy_base = 0;
    int          und_base = 0;

    task automatic drive_pend();
        if (pend.size() > 0) begin
            sample_valid = 1'b1;
            sample_l     = pend[0][31:16];
            sample_r     = pend[0][15:0];
        end else begin
            sample_valid = 1'b0;
        end
    endtask

    task automatic step();
        bit x;
        x = (sample_valid === 1'b1) && (sample_ready === 1'b1);
        @(negedge clk);
        if (x && pend.size() > 0) void'(pend.pop_front());
        drive_pend();
        phase     = (phase + 1) % 5;
        mclk_tick = (phase == 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        pend.push_back({l, r});
        drive_pend();
    endtask

    task automatic frame_start(input bit align, input bit push_edge,
                               input logic [15:0] l, input logic [15:0] r);
        int n;
        n = 0;
        lrck_in = 1'b0;
        steps(int'($urandom_range(1, 6)));
        if (align) begin
            while (!mclk_tick && n < 6) begin
                step();
                n++;
            end
        end
        cap_base  = ncap;
        busy_base = busy_acc;
        und_base  = und_acc;
        lrck_in   = 1'b1;
        if (push_edge) push(l, r);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        steps(2);
        while (busy === 1'b1 && n < 800) begin
            step();
            n++;
        end
        check("frame_end_busy", 64'(busy), 64'd0);
    endtask

    task automatic frame_checks(input string name, input logic [63:0] exp_bits,
                                input int exp_und, input bit chk_len);
        check({name, "_bits"}, cap, exp_bits);
        check({name, "_nbits"}, 64'(ncap - cap_base), 64'd64);
        check({name, "_underrun"}, 64'(und_acc - und_base), 64'(exp_und));
        if (chk_len) check({name, "_busy_len"}, 64'(busy_acc - busy_base), 64'd640);
    endtask

    task automatic run_ticks(input int count);
        int nt;
        nt = 0;
        step();
        while (nt < count) begin
            if (mclk_tick) nt++;
            step();
        end
    endtask

    logic [15:0] pl[3];
    logic [15:0] pr[3];

    initial begin
        // Reset with lrck high, then release: no frame without a fresh rising edge.
        steps(3);
        check("rst_sclk", 64'(sclk_out), 64'd0);
        check("rst_ws", 64'(ws_out), 64'd0);
        check("rst_sdata", 64'(sdata_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_ready", 64'(sample_ready), 64'd0);
        rst = 1'b1;
        step();
        check("ready_after_release", 64'(sample_ready), 64'd1);
        steps(20);
        check("no_frame_lrck_high", 64'(busy_acc), 64'd0);

        // Known pair, edge coincident with a tick.
        push(16'hA5C3, 16'h0F0F);
        steps(3);
        frame_start(1'b1, 1'b0, 16'h0, 16'h0);
        wait_idle();
        frame_checks("frame_a5c3", 64'h52E18000_07878000, 0, 1'b1);

        // Nothing held.
        frame_start(1'b0, 1'b0, 16'h0, 16'h0);
        wait_idle();
        frame_checks("frame_empty", 64'd0, 1, 1'b0);

        // Sample offered in the edge cycle plays in the following frame.
        frame_start(1'b0, 1'b1, 16'h1234, 16'hFEDC);
        wait_idle();
        frame_checks("frame_late_offer", 64'd0, 1, 1'b0);
        frame_start(1'b0, 1'b0, 16'h0, 16'h0);
        wait_idle();
        frame_checks("frame_1234", 64'h091A0000_7F6E0000, 0, 1'b0);

        // Valid held high with three pairs across four frames.
        for (int i = 0; i < 3; i++) begin
            pl[i] = 16'($urandom);
            pr[i] = 16'($urandom);
            push(pl[i], pr[i]);
        end
        steps(3);
        for (int i = 0; i < 4; i++) begin
            frame_start(1'b0, 1'b0, 16'h0, 16'h0);
            wait_idle();
            if (i < 3) frame_checks("frame_queue", stream_of(pl[i], pr[i]), 0, 1'b0);
            else       frame_checks("frame_queue_end", 64'd0, 1, 1'b0);
        end
        check("queue_drained", 64'(pend.size()), 64'd0);

        // Extra lrck edge mid-frame is ignored.
        push(16'h8001, 16'h7FFE);
        steps(3);
        frame_start(1'b1, 1'b0, 16'h0, 16'h0);
        run_ticks(40);
        lrck_in = 1'b0;
        step();
        lrck_in = 1'b1;
        wait_idle();
        frame_checks("frame_extra_edge", stream_of(16'h8001, 16'h7FFE), 0, 1'b1);
        steps(20);
        check("no_restart_after_extra_edge", 64'(busy), 64'd0);

        // Reset mid-frame with a pair held for the next frame.
        push(16'h1111, 16'h2222);
        steps(3);
        frame_start(1'b1, 1'b0, 16'h0, 16'h0);
        push(16'h3333, 16'h4444);
        run_ticks(70);
        check("queued_before_reset", 64'(pend.size()), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_sclk", 64'(sclk_out), 64'd0);
        check("midrst_ws", 64'(ws_out), 64'd0);
        check("midrst_sdata", 64'(sdata_out), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(sample_ready), 64'd0);
        pend.delete();
        drive_pend();
        steps(3);
        rst = 1'b1;
        step();
        check("ready_after_midrst", 64'(sample_ready), 64'd1);
        frame_start(1'b0, 1'b0, 16'h0, 16'h0);
        wait_idle();
        frame_checks("frame_after_rst", 64'd0, 1, 1'b0);

        // Random traffic and frame phases against the model.
        for (int k = 0; k < 6; k++) begin
            int np;
            np = int'($urandom_range(0, 2));
            for (int j = 0; j < np; j++) push(16'($urandom), 16'($urandom));
            steps(int'($urandom_range(1, 10)));
            frame_start(1'($urandom_range(0, 1)), 1'b0, 16'h0, 16'h0);
            wait_idle();
            steps(int'($urandom_range(0, 30)));
        end

        steps(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
